// File: rtl/traffic_pkg.sv
// traffic_pkg: shared constants and helpers for the lamp-bus monitor.
//   Z_*      one-hot lamp codes driven by the traffic-light controller
//   state_t  monitor FSM states
//   SEG_*    active-low seven-segment patterns, bit order gfedcba
package traffic_pkg;

    localparam logic [2:0] Z_RED = 3'b001;
    localparam logic [2:0] Z_YEL = 3'b010;
    localparam logic [2:0] Z_GRN = 3'b100;

    typedef enum logic {ACQ, TRACK} state_t;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0011000;

    function automatic logic is_onehot(logic [2:0] code);
        return (code == Z_RED) || (code == Z_YEL) || (code == Z_GRN);
    endfunction

    // Phase index of a legal code; only meaningful when is_onehot() holds.
    function automatic logic [1:0] phase_idx(logic [2:0] code);
        logic [1:0] idx;
        case (code)
            Z_YEL:   idx = 2'd1;
            Z_GRN:   idx = 2'd2;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/traffic_monitor_if.sv
// traffic_monitor_if: lamp bus plus monitor report signals.
//   z           lamp code from the controller
//   phase_done  one-cycle pulse at the end of a phase
//   last_phase  index of the phase that just ended
//   last_len    measured dwell of that phase
//   err_*       sticky error flags
//   HEX0/HEX1   rotation count, units/tens, active-low gfedcba
// master: drives z (controller / bench). slave: the monitor.
interface traffic_monitor_if;

    logic [2:0] z;
    logic       phase_done;
    logic [1:0] last_phase;
    logic [5:0] last_len;
    logic       err_onehot;
    logic       err_seq;
    logic       err_dur;
    logic [6:0] HEX0;
    logic [6:0] HEX1;

    modport master (
        output z,
        input  phase_done, last_phase, last_len, err_onehot, err_seq, err_dur, HEX0, HEX1
    );

    modport slave (
        input  z,
        output phase_done, last_phase, last_len, err_onehot, err_seq, err_dur, HEX0, HEX1
    );

endinterface

// File: rtl/seg7_enc.sv
// seg7_enc: combinational BCD digit to active-low seven-segment pattern.
//   bcd  in  4  digit 0..9 (10..15 blank the display)
//   seg  out 7  segments gfedcba, 0 = lit
module seg7_enc
    import traffic_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'b1111111;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/traffic_monitor.sv
// traffic_monitor: passive checker on the traffic-light lamp bus. Measures each
// phase's dwell, checks phase order 001->010->100->001 and dwell against DURx, raises
// sticky error flags and shows completed rotations on two seven-segment digits.
//   clk  in  system clock
//   rst  in  synchronous active-high reset
//   bus  traffic_monitor_if.slave (z in; phase report, error flags, HEX0/HEX1 out)
module traffic_monitor
    import traffic_pkg::*;
#(
    parameter int unsigned DUR0 = 11,
    parameter int unsigned DUR1 = 21,
    parameter int unsigned DUR2 = 31
) (
    input  logic               clk,
    input  logic               rst,
    traffic_monitor_if.slave   bus
);

    logic [2:0] z_q, z_p;
    state_t     state_q, state_d;
    logic [1:0] cur_q, cur_d;
    logic [5:0] run_len_q, run_len_d;
    logic       phase_done_q, phase_done_d;
    logic [1:0] last_phase_q, last_phase_d;
    logic [5:0] last_len_q, last_len_d;
    logic       err_onehot_q, err_onehot_d;
    logic       err_seq_q, err_seq_d;
    logic       err_dur_q, err_dur_d;
    logic [3:0] units_q, units_d, tens_q, tens_d;
    logic [6:0] hex0_q, hex0_d, hex1_q, hex1_d;

    logic       change, new_oh, rotate;
    logic [1:0] new_idx, next_idx;
    logic [5:0] dur_cur;

    assign change   = (z_q != z_p);
    assign new_oh   = is_onehot(z_q);
    assign new_idx  = phase_idx(z_q);
    assign next_idx = (cur_q == 2'd2) ? 2'd0 : cur_q + 2'd1;

    always_comb begin
        case (cur_q)
            2'd1:    dur_cur = 6'(DUR1);
            2'd2:    dur_cur = 6'(DUR2);
            default: dur_cur = 6'(DUR0);
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        run_len_d    = run_len_q;
        phase_done_d = 1'b0;
        last_phase_d = last_phase_q;
        last_len_d   = last_len_q;
        err_onehot_d = err_onehot_q;
        err_seq_d    = err_seq_q;
        err_dur_d    = err_dur_q;
        rotate       = 1'b0;
        case (state_q)
            ACQ: begin
                if (change && new_oh) begin
                    state_d   = TRACK;
                    cur_d     = new_idx;
                    run_len_d = 6'd1;
                end
            end
            TRACK: begin
                if (!change) begin
                    if (run_len_q != 6'd63) run_len_d = run_len_q + 6'd1;
                    // Over-long phase flagged as soon as it is known, not at phase end.
                    if (run_len_q > dur_cur) err_dur_d = 1'b1;
                end else begin
                    phase_done_d = 1'b1;
                    last_phase_d = cur_q;
                    last_len_d   = run_len_q;
                    if (new_oh) begin
                        if (run_len_q != dur_cur) err_dur_d = 1'b1;
                        if (new_idx != next_idx)  err_seq_d = 1'b1;
                        rotate    = (cur_q == 2'd2) && (new_idx == 2'd0);
                        cur_d     = new_idx;
                        run_len_d = 6'd1;
                    end else begin
                        err_onehot_d = 1'b1;
                        state_d      = ACQ;
                    end
                end
            end
            default: state_d = ACQ;
        endcase
    end

    // Two-digit BCD rotation counter, 99 wraps to 00.
    always_comb begin
        units_d = units_q;
        tens_d  = tens_q;
        if (rotate) begin
            if (units_q == 4'd9) begin
                units_d = 4'd0;
                tens_d  = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
            end else begin
                units_d = units_q + 4'd1;
            end
        end
    end

    seg7_enc u_enc0 (.bcd(units_d), .seg(hex0_d));
    seg7_enc u_enc1 (.bcd(tens_d),  .seg(hex1_d));

    always_ff @(posedge clk) begin
        if (rst) begin
            z_q          <= 3'b000;
            z_p          <= 3'b000;
            state_q      <= ACQ;
            cur_q        <= 2'd0;
            run_len_q    <= 6'd0;
            phase_done_q <= 1'b0;
            last_phase_q <= 2'd0;
            last_len_q   <= 6'd0;
            err_onehot_q <= 1'b0;
            err_seq_q    <= 1'b0;
            err_dur_q    <= 1'b0;
            units_q      <= 4'd0;
            tens_q       <= 4'd0;
            hex0_q       <= SEG_0;
            hex1_q       <= SEG_0;
        end else begin
            z_q          <= bus.z;
            z_p          <= z_q;
            state_q      <= state_d;
            cur_q        <= cur_d;
            run_len_q    <= run_len_d;
            phase_done_q <= phase_done_d;
            last_phase_q <= last_phase_d;
            last_len_q   <= last_len_d;
            err_onehot_q <= err_onehot_d;
            err_seq_q    <= err_seq_d;
            err_dur_q    <= err_dur_d;
            units_q      <= units_d;
            tens_q       <= tens_d;
            hex0_q       <= hex0_d;
            hex1_q       <= hex1_d;
        end
    end

    assign bus.phase_done = phase_done_q;
    assign bus.last_phase = last_phase_q;
    assign bus.last_len   = last_len_q;
    assign bus.err_onehot = err_onehot_q;
    assign bus.err_seq    = err_seq_q;
    assign bus.err_dur    = err_dur_q;
    assign bus.HEX0       = hex0_q;
    assign bus.HEX1       = hex1_q;

endmodule

// File: tb/tb_traffic_monitor.sv
// tb_traffic_monitor: drives lamp-code schedules into traffic_monitor, predicts each
// phase end into a scoreboard queue and compares it against every phase_done pulse;
// error flags and display are compared against a schedule-level model at checkpoints.
module tb_traffic_monitor;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    traffic_monitor_if mi ();

    traffic_monitor #(
        .DUR0(11),
        .DUR1(21),
        .DUR2(31)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(mi.slave)
    );

    typedef struct packed {
        logic [1:0] ph;
        logic [5:0] len;
    } ev_t;

    ev_t q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    int unsigned dur [3] = '{11, 21, 31};
    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000};

    // Schedule-level model
    logic [2:0] m_code;
    int         m_len;
    bit         m_track;
    bit         e_oh, e_seq, e_dur;
    int         m_rot;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int idx_of(logic [2:0] c);
        case (c)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return -1;
        endcase
    endfunction

    // Drive code for n sampling edges; predict the phase end this change causes.
    task automatic hold(input logic [2:0] code, input int n);
        int  pi, ni;
        ev_t ev;
        if (code != m_code) begin
            pi = idx_of(m_code);
            ni = idx_of(code);
            if (m_track) begin
                ev.ph  = 2'(pi);
                ev.len = 6'((m_len > 63) ? 63 : m_len);
                q.push_back(ev);
                if (ni >= 0) begin
                    if (m_len != int'(dur[pi])) e_dur = 1'b1;
                    if (ni != (pi + 1) % 3) e_seq = 1'b1;
                    if (pi == 2 && ni == 0) m_rot = (m_rot + 1) % 100;
                end else begin
                    e_oh    = 1'b1;
                    m_track = 1'b0;
                end
            end else if (ni >= 0) begin
                m_track = 1'b1;
            end
            m_code = code;
            m_len  = 0;
        end
        mi.z = code;
        repeat (n) @(posedge clk);
        #1;
        m_len += n;
    endtask

    task automatic checkpoint(input string tag);
        bit ed;
        ed = e_dur;
        if (m_track && m_len >= int'(dur[idx_of(m_code)]) + 3) ed = 1'b1;
        check_eq({tag, ".err_onehot"}, 32'(mi.err_onehot), 32'(e_oh));
        check_eq({tag, ".err_seq"},    32'(mi.err_seq),    32'(e_seq));
        check_eq({tag, ".err_dur"},    32'(mi.err_dur),    32'(ed));
        check_eq({tag, ".HEX0"},       32'(mi.HEX0),       32'(seg_tab[m_rot % 10]));
        check_eq({tag, ".HEX1"},       32'(mi.HEX1),       32'(seg_tab[m_rot / 10]));
    endtask

    task automatic do_reset(input string tag);
        check_eq({tag, ".pending_events"}, 32'(q.size()), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        m_code  = 3'b000;
        m_len   = 0;
        m_track = 1'b0;
        e_oh    = 1'b0;
        e_seq   = 1'b0;
        e_dur   = 1'b0;
        m_rot   = 0;
        check_eq({tag, ".phase_done"}, 32'(mi.phase_done), 32'd0);
        check_eq({tag, ".last_phase"}, 32'(mi.last_phase), 32'd0);
        check_eq({tag, ".last_len"},   32'(mi.last_len),   32'd0);
        checkpoint(tag);
        rst = 1'b0;
    endtask

    // Scoreboard: every pulse must match the oldest predicted phase end.
    always @(negedge clk) begin : sb
        ev_t ev;
        if (!rst && mi.phase_done === 1'b1) begin
            if (q.size() == 0) begin
                check_eq("unexpected_phase_done", 32'(mi.phase_done), 32'd0);
            end else begin
                ev = q.pop_front();
                check_eq("last_phase", 32'(mi.last_phase), 32'(ev.ph));
                check_eq("last_len",   32'(mi.last_len),   32'(ev.len));
            end
        end
    end

    initial begin
        rst  = 1'b1;
        mi.z = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        do_reset("init");

        // Three clean rotations: nine phase ends, count 03
        for (int r = 0; r < 3; r++) begin
            hold(3'b001, 11);
            hold(3'b010, 21);
            hold(3'b100, 31);
        end
        hold(3'b001, 5);
        checkpoint("rot3");
        check_eq("rot3.HEX0_is_3", 32'(mi.HEX0), 32'(7'b0110000));
        hold(3'b001, 6);

        // Over-long 001: flag rises one edge after run_len reaches 12
        do_reset("long_rst");
        hold(3'b001, 13);
        check_eq("long.err_dur_early", 32'(mi.err_dur), 32'd0);
        hold(3'b001, 1);
        check_eq("long.err_dur_rise", 32'(mi.err_dur), 32'd1);
        hold(3'b001, 1);
        hold(3'b010, 5);
        checkpoint("long");

        // Skipped phase: 001 -> 100
        do_reset("seq_rst");
        hold(3'b001, 11);
        hold(3'b100, 31);
        hold(3'b001, 5);
        checkpoint("seq");
        check_eq("seq.err_seq_set", 32'(mi.err_seq), 32'd1);
        hold(3'b001, 6);

        // Illegal code glitch inside 010, then re-acquire on an out-of-order code
        do_reset("glitch_rst");
        hold(3'b001, 11);
        hold(3'b010, 5);
        hold(3'b011, 1);
        hold(3'b100, 5);
        checkpoint("glitch");
        hold(3'b100, 26);
        hold(3'b001, 5);
        checkpoint("glitch_after");
        hold(3'b001, 6);

        // Rotation count wrap 99 -> 00
        do_reset("wrap_rst");
        hold(3'b001, 11);
        for (int r = 0; r < 100; r++) begin
            hold(3'b010, 21);
            hold(3'b100, 31);
            hold(3'b001, 5);
            if (r == 98) begin
                checkpoint("rot99");
                check_eq("rot99.HEX0", 32'(mi.HEX0), 32'(7'b0011000));
                check_eq("rot99.HEX1", 32'(mi.HEX1), 32'(7'b0011000));
            end
            if (r == 99) begin
                checkpoint("rot100");
                check_eq("rot100.HEX0", 32'(mi.HEX0), 32'(7'b1000000));
                check_eq("rot100.HEX1", 32'(mi.HEX1), 32'(7'b1000000));
            end
            hold(3'b001, 6);
        end

        // Error, then reset mid-phase: no pulse, flags clear, next phase exact
        hold(3'b100, 5);
        checkpoint("pre_mid_rst");
        hold(3'b100, 3);
        do_reset("mid_rst");
        hold(3'b100, 31);
        hold(3'b001, 5);
        checkpoint("post_rst");
        check_eq("post_rst.HEX0_is_1", 32'(mi.HEX0), 32'(7'b1111001));

        repeat (3) @(posedge clk);
        #1;
        check_eq("final.pending_events", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
